axis_string_to_char_converter: RTL and testbench
================================================

# axis_string_to_char_converter

- Serializes one wide AXI-Stream word holding a fixed-width character string into a stream of 8-bit characters.
- Complement of `axis_char_to_string_converter`: sits on the transmit side of the UART/1553 core and feeds a byte-wide UART TX path from string-producing logic.
- Leading NUL padding can be stripped, so Verilog string literals shorter than the word emit only their real characters.
- Last character of each string is flagged with `m_axis_tlast`.

## Interface
- `slave_width`, 21, string width in bytes; `s_axis_tdata` is `slave_width*8` bits.
- `skip_null`, 1, when 1, leading NUL (0x00) bytes at the MSB end are not emitted; when 0, all `slave_width` bytes are emitted.
- `aclk`  in  1  clock; all logic on rising edge.
- `arst`  in  1  synchronous, active-high reset.
- `s_axis_tdata`  in  `slave_width*8`  string word; first character in bits `[slave_width*8-1 -: 8]` (Verilog string-literal order).
- `s_axis_tvalid`  in  1  string word valid.
- `s_axis_tready`  out  1  block idle and able to accept a word.
- `m_axis_tdata`  out  8  current character.
- `m_axis_tvalid`  out  1  character valid.
- `m_axis_tready`  in  1  downstream accepts character.
- `m_axis_tlast`  out  1  high with the final character of the word.

## Operation
- Two states: IDLE and SEND.
- IDLE:
  - `s_axis_tready`=1, `m_axis_tvalid`=0.
  - On `s_axis_tvalid && s_axis_tready`: register the word into a shift/index buffer.
  - Set byte index `idx` = position of the first emitted byte:
    - `skip_null`=1: highest-order nonzero byte, from a priority encode over the incoming word.
    - `skip_null`=0: `slave_width-1`.
  - Go to SEND.
  - All-zero word with `skip_null`=1: consumed, nothing emitted, remain IDLE.
- SEND:
  - `s_axis_tready`=0, `m_axis_tvalid`=1.
  - `m_axis_tdata` = buffer byte `idx`; `m_axis_tlast` = (`idx`==0).
  - Byte order is MSB byte first, down to byte 0.
  - On `m_axis_tvalid && m_axis_tready`:
    - If `idx`==0: go to IDLE.
    - Otherwise `idx` decrements and the next byte is presented.
  - Without `m_axis_tready`, `m_axis_tdata`, `m_axis_tvalid` and `m_axis_tlast` hold stable; AXIS rule, valid never drops before handshake.
- Only leading NULs are skipped. NUL bytes after the first nonzero byte are emitted as data.
- `idx` width is `$clog2(slave_width)` bits; `slave_width`=1 must be supported (single byte, tlast always 1).

## Timing
- Reset (`arst` high at a clock edge):
  - State IDLE; `m_axis_tdata`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `s_axis_tready`=0.
  - Buffer and `idx` cleared.
- First edge after `arst` drops: `s_axis_tready`=1.
- Reset mid-SEND aborts the word immediately. Remaining bytes are discarded; no tlast is required.
- Latency: the word accepted at edge N presents its first character at edge N+1 (registered outputs).
- Throughput, downstream always ready: K emitted bytes take K cycles in SEND, plus 1 IDLE cycle before the next word is accepted. No overlap of load and send.
- All outputs are registered; there is no combinational path from `m_axis_tready` or `s_axis_tvalid` to any output.
- `s_axis_tvalid` asserted during SEND is ignored (ready=0); the upstream word must stay held until IDLE.

## Test plan
- "Hello" (0x48656C6C6F) zero-padded to 21 bytes, `skip_null`=1, tready=1 -> 0x48,0x65,0x6C,0x6C,0x6F on 5 consecutive cycles. tlast only on 0x6F. `s_axis_tready` high again 1 cycle later.
- Same word with `m_axis_tready` = `$random%2` -> identical byte sequence, no drops or duplicates. Data, valid and last hold stable while tready=0.
- Full 21-byte word 0x41..0x55 -> 21 bytes in order 0x41 first; tlast on 0x55.
- Word 0x00..00 41 00 42 (NUL embedded) -> 0x41,0x00,0x42 emitted, tlast on 0x42. All-zero word -> no m_axis_tvalid, `s_axis_tready` stays high.
- `skip_null`=0 with "Hi" padded -> 19×0x00 then 0x48,0x69; tlast on 0x69.
- `arst` pulsed for 1 cycle after the 2nd byte of "Hello":
  - Next cycle: `m_axis_tvalid`=0, `s_axis_tready`=0.
  - Cycle after: `s_axis_tready`=1.
  - A following "AB" word emits 0x41,0x42 cleanly.

Source files
------------

// File: rtl/axis_string_to_char_converter_if.sv
// AXI-Stream bundle shared by the wide string side and the byte-wide character side.
// The data width is set per instance; tlast is carried on both sides.
interface axis_string_to_char_converter_if #(
  parameter int data_width = 8
);
  logic [data_width-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_string_to_char_converter.sv
// Serializes one wide string word into a byte stream, first character from the MSB end.
// Leading NUL padding is optionally dropped; the final character carries tlast.
module axis_string_to_char_converter #(
  parameter int slave_width = 21,
  parameter bit skip_null   = 1'b1
) (
  input  logic                                aclk,
  input  logic                                arst,
  axis_string_to_char_converter_if.slave      s_axis,
  axis_string_to_char_converter_if.master     m_axis
);

  localparam int data_width = slave_width * 8;
  localparam int idx_width  = (slave_width > 1) ? $clog2(slave_width) : 1;
  localparam logic [idx_width-1:0] last_idx = idx_width'(slave_width - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                 state_reg, state_next;
  logic [data_width-1:0]  buf_reg, buf_next;
  logic [idx_width-1:0]   idx_reg, idx_next;
  logic [7:0]             m_tdata_reg, m_tdata_next;
  logic                   m_tvalid_reg, m_tvalid_next;
  logic                   m_tlast_reg, m_tlast_next;
  logic                   s_tready_reg, s_tready_next;

  logic [7:0]             in_bytes  [slave_width];
  logic [7:0]             buf_bytes [slave_width];
  logic [slave_width-1:0] in_nonzero;
  logic [idx_width-1:0]   first_idx;
  logic [idx_width-1:0]   idx_dec;
  logic                   word_has_data;

  generate
    for (genvar gi = 0; gi < slave_width; gi++) begin : g_bytes
      assign in_bytes[gi]   = s_axis.tdata[gi*8 +: 8];
      assign buf_bytes[gi]  = buf_reg[gi*8 +: 8];
      assign in_nonzero[gi] = |s_axis.tdata[gi*8 +: 8];
    end
  endgenerate

  // Ascending scan so the highest-order nonzero byte wins.
  always_comb begin
    first_idx     = last_idx;
    word_has_data = 1'b1;
    if (skip_null) begin
      first_idx     = '0;
      word_has_data = |in_nonzero;
      for (int i = 0; i < slave_width; i++) begin
        if (in_nonzero[i]) begin
          first_idx = idx_width'(i);
        end
      end
    end
  end

  assign idx_dec = idx_reg - 1'b1;

  always_ff @(posedge aclk) begin
    if (arst) begin
      state_reg    <= IDLE;
      buf_reg      <= '0;
      idx_reg      <= '0;
      m_tdata_reg  <= '0;
      m_tvalid_reg <= 1'b0;
      m_tlast_reg  <= 1'b0;
      s_tready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      buf_reg      <= buf_next;
      idx_reg      <= idx_next;
      m_tdata_reg  <= m_tdata_next;
      m_tvalid_reg <= m_tvalid_next;
      m_tlast_reg  <= m_tlast_next;
      s_tready_reg <= s_tready_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    buf_next      = buf_reg;
    idx_next      = idx_reg;
    m_tdata_next  = m_tdata_reg;
    m_tvalid_next = m_tvalid_reg;
    m_tlast_next  = m_tlast_reg;
    s_tready_next = s_tready_reg;

    case (state_reg)
      IDLE: begin
        m_tvalid_next = 1'b0;
        m_tlast_next  = 1'b0;
        // Ready is low only in the first cycle out of reset.
        if (!s_tready_reg) begin
          s_tready_next = 1'b1;
        end else if (s_axis.tvalid && word_has_data) begin
          buf_next      = s_axis.tdata;
          idx_next      = first_idx;
          m_tdata_next  = in_bytes[first_idx];
          m_tvalid_next = 1'b1;
          m_tlast_next  = (first_idx == '0);
          s_tready_next = 1'b0;
          state_next    = SEND;
        end
      end

      SEND: begin
        if (m_axis.tready) begin
          if (idx_reg == '0) begin
            m_tdata_next  = '0;
            m_tvalid_next = 1'b0;
            m_tlast_next  = 1'b0;
            s_tready_next = 1'b1;
            state_next    = IDLE;
          end else begin
            idx_next     = idx_dec;
            m_tdata_next = buf_bytes[idx_dec];
            m_tlast_next = (idx_dec == '0);
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign s_axis.tready = s_tready_reg;
  assign m_axis.tdata  = m_tdata_reg;
  assign m_axis.tvalid = m_tvalid_reg;
  assign m_axis.tlast  = m_tlast_reg;

endmodule

// File: tb/tb_axis_string_to_char_converter.sv
// Scoreboard bench: expected characters are queued when a word is driven and
// checked as each character handshake completes on the byte-wide side.
module tb_axis_string_to_char_converter;

  localparam int SW = 21;
  localparam int DW = SW * 8;

  logic tb_data_clk = 1'b0;
  always #5 tb_data_clk = ~tb_data_clk;

  logic arst;

  axis_string_to_char_converter_if #(.data_width(DW)) s_str ();
  axis_string_to_char_converter_if #(.data_width(8))  m_str ();
  axis_string_to_char_converter_if #(.data_width(DW)) s_raw ();
  axis_string_to_char_converter_if #(.data_width(8))  m_raw ();

  axis_string_to_char_converter #(.slave_width(SW), .skip_null(1'b1)) u_dut (
    .aclk   (tb_data_clk),
    .arst   (arst),
    .s_axis (s_str.slave),
    .m_axis (m_str.master)
  );

  axis_string_to_char_converter #(.slave_width(SW), .skip_null(1'b0)) u_dut_raw (
    .aclk   (tb_data_clk),
    .arst   (arst),
    .s_axis (s_raw.slave),
    .m_axis (m_raw.master)
  );

  int assertions_count = 0;
  int failures_count   = 0;
  bit rand_ready       = 1'b0;

  logic [8:0] exp_q [$];
  logic [8:0] raw_q [$];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertions_count++;
    if (got !== exp) begin
      failures_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Downstream ready changes just after the rising edge so it is stable at the falling edge.
  initial begin
    m_str.tready = 1'b1;
    m_raw.tready = 1'b1;
    forever begin
      @(posedge tb_data_clk);
      #1;
      m_str.tready = rand_ready ? 1'($urandom % 2) : 1'b1;
    end
  end

  // Character monitor for the NUL-stripping instance, including hold-while-stalled checks.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [8:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge tb_data_clk);
      if (arst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_value("hold_valid", 32'(m_str.tvalid), 32'(1));
          check_value("hold_data", 32'(m_str.tdata), 32'(prev_data));
          check_value("hold_last", 32'(m_str.tlast), 32'(prev_last));
        end
        if (m_str.tvalid && m_str.tready) begin
          if (exp_q.size() == 0) begin
            check_value("unexpected_byte", 32'(m_str.tvalid), 32'(0));
          end else begin
            e = exp_q.pop_front();
            $display("char data=0x%02h last=%0b expected data=0x%02h last=%0b",
                     m_str.tdata, m_str.tlast, e[7:0], e[8]);
            check_value("byte_data", 32'(m_str.tdata), 32'(e[7:0]));
            check_value("byte_last", 32'(m_str.tlast), 32'(e[8]));
          end
        end
        prev_stall = m_str.tvalid && !m_str.tready;
        prev_data  = m_str.tdata;
        prev_last  = m_str.tlast;
      end
    end
  end

  // Character monitor for the instance that emits every byte.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge tb_data_clk);
      if (!arst && m_raw.tvalid && m_raw.tready) begin
        if (raw_q.size() == 0) begin
          check_value("raw_unexpected_byte", 32'(m_raw.tvalid), 32'(0));
        end else begin
          e = raw_q.pop_front();
          $display("raw char data=0x%02h last=%0b expected data=0x%02h last=%0b",
                   m_raw.tdata, m_raw.tlast, e[7:0], e[8]);
          check_value("raw_byte_data", 32'(m_raw.tdata), 32'(e[7:0]));
          check_value("raw_byte_last", 32'(m_raw.tlast), 32'(e[8]));
        end
      end
    end
  end

  // Queue the expected characters, then present the word until it is accepted.
  task automatic send_word(input logic [DW-1:0] w, input bit raw, input bit skip);
    bit         started;
    logic [7:0] b;
    int         t;
    started = !skip;
    for (int i = SW - 1; i >= 0; i--) begin
      b = w[i*8 +: 8];
      if (b != 8'h00) started = 1'b1;
      if (started) begin
        if (raw) raw_q.push_back({(i == 0), b});
        else     exp_q.push_back({(i == 0), b});
      end
    end
    $display("word %0h raw=%0b", w, raw);
    @(negedge tb_data_clk);
    if (raw) begin
      s_raw.tdata  = w;
      s_raw.tvalid = 1'b1;
    end else begin
      s_str.tdata  = w;
      s_str.tvalid = 1'b1;
    end
    t = 0;
    while (((raw ? s_raw.tready : s_str.tready) == 1'b0) && t < 200) begin
      @(negedge tb_data_clk);
      t++;
    end
    if (t >= 200) begin
      check_value("accept_timeout", 32'(raw ? s_raw.tready : s_str.tready), 32'(1));
    end
    @(posedge tb_data_clk);
    #1;
    s_str.tvalid = 1'b0;
    s_raw.tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || raw_q.size() != 0 || m_str.tvalid || m_raw.tvalid) && t < 2000) begin
      @(negedge tb_data_clk);
      t++;
    end
    check_value("drain", 32'(exp_q.size() + raw_q.size()), 32'(0));
  endtask

  function automatic logic [DW-1:0] full_word();
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < SW; i++) begin
      w[(SW - 1 - i)*8 +: 8] = 8'(8'h41 + i);
    end
    return w;
  endfunction

  initial begin
    int  n;
    int  seen;
    bit  any_valid;
    bit  first;

    arst         = 1'b1;
    s_str.tdata  = '0;
    s_str.tvalid = 1'b0;
    s_str.tlast  = 1'b0;
    s_raw.tdata  = '0;
    s_raw.tvalid = 1'b0;
    s_raw.tlast  = 1'b0;

    repeat (3) @(posedge tb_data_clk);
    @(negedge tb_data_clk);
    check_value("rst_tvalid", 32'(m_str.tvalid), 32'(0));
    check_value("rst_tready", 32'(s_str.tready), 32'(0));
    check_value("rst_tdata", 32'(m_str.tdata), 32'(0));
    check_value("rst_tlast", 32'(m_str.tlast), 32'(0));
    arst = 1'b0;
    @(negedge tb_data_clk);
    check_value("post_rst_tready", 32'(s_str.tready), 32'(1));

    // "Hello" with downstream always ready: latency, five-cycle burst, ready one cycle later.
    send_word(DW'(40'h48656C6C6F), 1'b0, 1'b1);
    n     = 0;
    first = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge tb_data_clk);
      if (first) begin
        check_value("first_char_latency", 32'(m_str.tvalid), 32'(1));
        first = 1'b0;
      end
      if (m_str.tvalid) n++;
      if (m_str.tvalid && m_str.tready && m_str.tlast) break;
    end
    check_value("hello_cycles", 32'(n), 32'(5));
    @(negedge tb_data_clk);
    check_value("hello_ready_again", 32'(s_str.tready), 32'(1));
    wait_idle();

    // Random downstream backpressure.
    rand_ready = 1'b1;
    send_word(DW'(40'h48656C6C6F), 1'b0, 1'b1);
    wait_idle();
    send_word(full_word(), 1'b0, 1'b1);
    wait_idle();
    rand_ready = 1'b0;
    @(posedge tb_data_clk);

    // Embedded NUL is data; an all-zero word produces nothing.
    send_word(DW'(24'h410042), 1'b0, 1'b1);
    wait_idle();
    send_word('0, 1'b0, 1'b1);
    any_valid = 1'b0;
    repeat (6) begin
      @(negedge tb_data_clk);
      any_valid = any_valid | m_str.tvalid;
    end
    check_value("zero_word_no_valid", 32'(any_valid), 32'(0));
    check_value("zero_word_ready", 32'(s_str.tready), 32'(1));

    // Padding kept: 19 NULs then "Hi".
    send_word(DW'(16'h4869), 1'b1, 1'b0);
    wait_idle();

    // Reset after the second character of "Hello".
    send_word(DW'(40'h48656C6C6F), 1'b0, 1'b1);
    seen = 0;
    for (int c = 0; c < 50 && seen < 2; c++) begin
      @(negedge tb_data_clk);
      if (m_str.tvalid && m_str.tready) seen++;
    end
    check_value("reset_prefix_seen", 32'(seen), 32'(2));
    @(posedge tb_data_clk);
    #1;
    arst = 1'b1;
    @(posedge tb_data_clk);
    @(negedge tb_data_clk);
    check_value("midrst_tvalid", 32'(m_str.tvalid), 32'(0));
    check_value("midrst_tready", 32'(s_str.tready), 32'(0));
    arst = 1'b0;
    exp_q.delete();
    @(negedge tb_data_clk);
    check_value("midrst_ready_again", 32'(s_str.tready), 32'(1));
    send_word(DW'(16'h4142), 1'b0, 1'b1);
    wait_idle();

    check_value("final_queue_empty", 32'(exp_q.size() + raw_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", assertions_count, failures_count);
    $finish;
  end

endmodule
